// File: rtl/moore_seq_ctrl.sv
// moore_seq_ctrl: sends a latched bit pattern MSB-first onto X and counts Z rising edges.
//   CLK        rising-edge clock
//   RESET_N    asynchronous active-low reset
//   START      run request, sampled only in IDLE
//   PATTERN    PAT_W-bit pattern, bit PAT_W-1 sent first
//   REPEAT     back-to-back pattern repetitions; 0 finishes at once
//   Z          detector output being counted
//   X          registered detector input
//   BUSY       high while shifting and draining
//   DONE       one-cycle completion pulse
//   HIT_COUNT  saturating count of Z rising edges in the last run
module moore_seq_ctrl #(
    parameter int PAT_W     = 4,
    parameter int REP_W     = 4,
    parameter int CNT_W     = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [PAT_W-1:0] PATTERN,
    input  logic [REP_W-1:0] REPEAT,
    input  logic             Z,
    output logic             X,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] HIT_COUNT
);
    localparam int BIT_W = PAT_W > 1 ? $clog2(PAT_W) : 1;
    localparam int DRN_W = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC) : 1;
    localparam logic [BIT_W-1:0] TOP_BIT = BIT_W'(PAT_W - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, FIN} state_t;
    state_t           state;
    logic [PAT_W-1:0] pat;
    logic [BIT_W-1:0] bit_idx;
    logic [REP_W-1:0] rep_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic             z_q;
    logic [BIT_W-1:0] bit_nxt;
    logic             hit;
    // bit_idx is the index of the bit currently on X
    assign bit_nxt = bit_idx - BIT_W'(1);
    assign hit     = (state == SHIFT || state == DRAIN) && Z && !z_q && !(&HIT_COUNT);
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            pat       <= '0;
            bit_idx   <= '0;
            rep_cnt   <= '0;
            drain_cnt <= '0;
            z_q       <= 1'b0;
            X         <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            HIT_COUNT <= '0;
        end else begin
            z_q <= Z;
            if (hit) HIT_COUNT <= HIT_COUNT + CNT_W'(1);
            case (state)
                IDLE: if (START) begin
                    HIT_COUNT <= '0;
                    if (REPEAT != '0) begin
                        state   <= SHIFT;
                        pat     <= PATTERN;
                        rep_cnt <= REPEAT;
                        bit_idx <= TOP_BIT;
                        X       <= PATTERN[PAT_W-1];
                        BUSY    <= 1'b1;
                    end else begin
                        state <= FIN;
                        DONE  <= 1'b1;
                    end
                end
                SHIFT: if (bit_idx == '0) begin
                    if (rep_cnt == REP_W'(1)) begin
                        state     <= DRAIN;
                        X         <= 1'b0;
                        drain_cnt <= DRN_W'(DRAIN_CYC - 1);
                    end else begin
                        rep_cnt <= rep_cnt - REP_W'(1);
                        bit_idx <= TOP_BIT;
                        X       <= pat[PAT_W-1];
                    end
                end else begin
                    bit_idx <= bit_nxt;
                    X       <= pat[bit_nxt];
                end
                DRAIN: if (drain_cnt == '0) begin
                    state <= FIN;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt - DRN_W'(1);
                end
                default: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end
endmodule
